burst_ring_fifo: RTL and testbench
==================================

Name: burst_ring_fifo

Overview:
Parametrised ring-buffer FIFO between the DMA read engine and the VRSM accelerator datapath.
- Valid/ready handshake on both sides.
- Exact full/empty; no slot is sacrificed.
- Occupancy level output and programmable almost-full/almost-empty flags.
- Burst-granular flags, so the DMA issues a read burst only when a whole burst fits and the consumer starts only when a whole burst is resident.
- Synchronous flush and a sticky overflow error.

Parameters:
DATA_WIDTH, 32, word width in bits
DEPTH, 256, number of entries; power of two, >= BURST_LENGTH, >= 2
BURST_LENGTH, 128, words per DMA burst; 1..DEPTH
AF_THRESH, DEPTH-BURST_LENGTH, almost_full asserts when level >= AF_THRESH
AE_THRESH, BURST_LENGTH, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of contents, pointers and error flag
in_valid  in  1  producer has a word on in_data
in_ready  out  1  FIFO can accept a word (= !full)
in_data  in  DATA_WIDTH  write data
out_valid  out  1  a word is available (= !empty)
out_ready  in  1  consumer takes out_data this cycle
out_data  out  DATA_WIDTH  head-of-queue word (first-word fall-through)
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
burst_avail  out  1  level >= BURST_LENGTH
burst_space  out  1  DEPTH - level >= BURST_LENGTH
overflow  out  1  sticky: set when in_valid && !in_ready

Behaviour:
- Reset (async assert, sync-deasserted externally): wptr=0, rptr=0, level=0, overflow=0.
  - Therefore in_ready=1, out_valid=0, almost_empty=1, burst_avail=0, burst_space=1, and almost_full=(AF_THRESH==0).
  - Storage is not reset; out_data is don't-care while out_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Full/empty come from the level counter: full = (level==DEPTH), empty = (level==0).
- Write fire = in_valid && in_ready. mem[wptr] <= in_data, then wptr++.
- Read fire = out_valid && out_ready. rptr++.
- out_data = mem[rptr], combinational from registered storage.
- Latency: a word written at edge N is visible on out_data with out_valid=1 after edge N. No same-cycle bypass from in_data to out_data.
- Level update: +1 on write only, -1 on read only, unchanged when both fire or neither fires.
- Simultaneous write and read:
  - When 0 < level < DEPTH, both fire and level holds.
  - When full, the write is refused (in_ready=0) even if a read fires the same cycle. There is no combinational ready path from out_ready.
  - When empty, only the write fires.
- All status flags are combinational from the registered level, so they are valid in the cycle after the update.
- flush has priority over write and read in the same cycle: wptr=rptr=0, level=0, overflow=0. Data presented that cycle is dropped.
- overflow sets when in_valid && !in_ready and holds until rst or flush. Setting overflow does not alter FIFO contents.
- Reset mid-burst aborts immediately; all partially transferred data is discarded.
- Elaboration-time assertions check the parameter legality: DEPTH is a power of two, BURST_LENGTH <= DEPTH, and both thresholds <= DEPTH.

Decomposition:
- Shared package buffer_pkg holds:
  - function ptr_w(depth) = $clog2(depth)
  - function lvl_w(depth) = $clog2(depth)+1
  - the default DATA_WIDTH/BURST_LENGTH localparams shared with the DMA engine
- One sub-module, ring_ptr_ctrl, holds the pointers, level counter, fire logic, flags and overflow. It is parametrised by DEPTH, BURST_LENGTH and the thresholds and has no data path.
- The storage array and out_data mux stay in burst_ring_fifo.

Test Plan:
- Bench parameters for all scenarios: DEPTH=8, BURST_LENGTH=4, AF=6, AE=2, DATA_WIDTH=32.
- Reset then write 0x10..0x17 back-to-back, out_ready=0:
  - in_ready drops after the 8th write, level=8, almost_full=1 from level 6.
  - burst_avail=1 from level 4; burst_space=0 from level 5.
- From full, in_valid=1 with 0xDEAD while out_ready=1 for one cycle:
  - Write is refused and overflow=1.
  - out_data=0x10 is consumed, level=7.
  - The next cycle 0xDEAD is accepted.
- Stream 20 words with in_valid=out_ready=1 continuously:
  - Both pointers wrap; level stays constant at 1 after the first word.
  - Output order equals input order; no words are dropped.
- Write 0xA into the empty FIFO with out_ready=1:
  - out_valid=0 in the write cycle; out_valid=1 and out_data=0xA next cycle.
  - Popped the following cycle, giving level 0 and almost_empty=1.
- Fill to level 5 and set overflow, then assert flush with in_valid=1 and out_ready=1:
  - Next cycle level=0, out_valid=0, overflow=0.
  - The input word is dropped.
- Assert rst asynchronously mid-stream at level 3:
  - Outputs go immediately to reset values (level=0, in_ready=1, out_valid=0).
  - Normal operation resumes after deassertion.

Source files
------------

// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared buffer widths and DMA burst defaults
package buffer_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_BURST_LENGTH = 128;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full buffer (level == depth) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/burst_ring_fifo_if.sv
// rtl/burst_ring_fifo_if.sv - producer/consumer valid-ready streams of the burst FIFO
interface burst_ring_fifo_if #(
  parameter int DATA_WIDTH = buffer_pkg::DEF_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/ring_ptr_ctrl.sv
// rtl/ring_ptr_ctrl.sv - pointers, occupancy, burst/threshold flags and sticky overflow
module ring_ptr_ctrl
  import buffer_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int BURST_LENGTH = DEF_BURST_LENGTH,
  parameter int AF_THRESH    = DEPTH - BURST_LENGTH,
  parameter int AE_THRESH    = BURST_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     out_ready,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     wr_en,
  output logic [ptr_w(DEPTH)-1:0]  wptr,
  output logic [ptr_w(DEPTH)-1:0]  rptr,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     burst_avail,
  output logic                     burst_space,
  output logic                     overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);
  localparam logic [LW-1:0] BA_L   = LW'(BURST_LENGTH);
  localparam logic [LW-1:0] BS_L   = LW'(DEPTH - BURST_LENGTH);

  logic wr_fire;
  logic rd_fire;

  // Ready depends only on the registered level, never on out_ready.
  assign in_ready  = (level != FULL_L);
  assign out_valid = (level != '0);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_en     = wr_fire && !flush;

  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);
  assign burst_avail  = (level >= BA_L);
  assign burst_space  = (level <= BS_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_fire) wptr <= wptr + PW'(1);
      if (rd_fire) rptr <= rptr + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/burst_ring_fifo.sv
// rtl/burst_ring_fifo.sv - DMA-to-accelerator ring FIFO with burst-granular flags
module burst_ring_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = 256,
  parameter int BURST_LENGTH = DEF_BURST_LENGTH,
  parameter int AF_THRESH    = DEPTH - BURST_LENGTH,
  parameter int AE_THRESH    = BURST_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  burst_ring_fifo_if.slave         bus,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     burst_avail,
  output logic                     burst_space,
  output logic                     overflow
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("burst_ring_fifo: DEPTH must be a power of two >= 2");
  end
  if ((BURST_LENGTH < 1) || (BURST_LENGTH > DEPTH)) begin : g_bad_burst
    $error("burst_ring_fifo: BURST_LENGTH must be in 1..DEPTH");
  end
  if ((AF_THRESH < 0) || (AF_THRESH > DEPTH) || (AE_THRESH < 0) || (AE_THRESH > DEPTH)) begin : g_bad_thresh
    $error("burst_ring_fifo: thresholds must be in 0..DEPTH");
  end

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ptr_w(DEPTH)-1:0] wptr;
  logic [ptr_w(DEPTH)-1:0] rptr;
  logic                    wr_en;

  ring_ptr_ctrl #(
    .DEPTH        (DEPTH),
    .BURST_LENGTH (BURST_LENGTH),
    .AF_THRESH    (AF_THRESH),
    .AE_THRESH    (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (bus.in_valid),
    .out_ready    (bus.out_ready),
    .in_ready     (bus.in_ready),
    .out_valid    (bus.out_valid),
    .wr_en        (wr_en),
    .wptr         (wptr),
    .rptr         (rptr),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .burst_avail  (burst_avail),
    .burst_space  (burst_space),
    .overflow     (overflow)
  );

  // Storage is deliberately unreset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= bus.in_data;
  end

  assign bus.out_data = mem[rptr];

endmodule

// File: tb/tb_burst_ring_fifo.sv
// tb/tb_burst_ring_fifo.sv - self-checking bench for burst_ring_fifo against a queue model
module tb_burst_ring_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int BL = 4;
  localparam int AF = 6;
  localparam int AE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] level;
  logic       almost_full, almost_empty, burst_avail, burst_space, overflow;

  burst_ring_fifo_if #(.DATA_WIDTH(DW)) bus ();

  burst_ring_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LENGTH(BL), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .burst_avail(burst_avail), .burst_space(burst_space), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          m_ovf;

  typedef struct {
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    int          lvl;
    bit          ir;
    bit          af;
    bit          ba;
    bit          bs;
    bit          ovf;
    logic [31:0] head;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit f, input bit iv, input logic [31:0] d, input bit ordy);
    flush         = f;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("level", 32'(level), 32'(n));
    chk("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("burst_avail", 32'(burst_avail), 32'(n >= BL));
    chk("burst_space", 32'(burst_space), 32'((DEPTH - n) >= BL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (n > 0) chk("out_data", bus.out_data, q[0]);
  endtask

  // Compare current outputs, clock once, then advance the model from the pre-edge inputs.
  task automatic step();
    bit wr, rd, ov;
    check_model();
    wr = bus.in_valid && (q.size() < DEPTH);
    rd = bus.out_ready && (q.size() > 0);
    ov = bus.in_valid && (q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (ov) m_ovf = 1'b1;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(bus.in_data);
    end
  endtask

  initial begin
    tbl[0] = '{1, 32'h10,   0, 1, 1, 0, 0, 1, 0, 32'h10};
    tbl[1] = '{1, 32'h11,   0, 2, 1, 0, 0, 1, 0, 32'h10};
    tbl[2] = '{1, 32'h12,   0, 3, 1, 0, 0, 1, 0, 32'h10};
    tbl[3] = '{1, 32'h13,   0, 4, 1, 0, 1, 1, 0, 32'h10};
    tbl[4] = '{1, 32'h14,   0, 5, 1, 0, 1, 0, 0, 32'h10};
    tbl[5] = '{1, 32'h15,   0, 6, 1, 1, 1, 0, 0, 32'h10};
    tbl[6] = '{1, 32'h16,   0, 7, 1, 1, 1, 0, 0, 32'h10};
    tbl[7] = '{1, 32'h17,   0, 8, 0, 1, 1, 0, 0, 32'h10};
    tbl[8] = '{1, 32'hDEAD, 1, 7, 1, 1, 1, 0, 1, 32'h11};
    tbl[9] = '{1, 32'hDEAD, 0, 8, 0, 1, 1, 0, 1, 32'h11};

    m_ovf = 1'b0;
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    chk("reset_level", 32'(level), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_almost_full", 32'(almost_full), 0);
    chk("reset_almost_empty", 32'(almost_empty), 1);
    chk("reset_burst_avail", 32'(burst_avail), 0);
    chk("reset_burst_space", 32'(burst_space), 1);
    chk("reset_overflow", 32'(overflow), 0);

    for (int i = 0; i < 10; i++) begin
      drive(0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      step();
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].ir));
      chk("tbl_almost_full", 32'(almost_full), 32'(tbl[i].af));
      chk("tbl_burst_avail", 32'(burst_avail), 32'(tbl[i].ba));
      chk("tbl_burst_space", 32'(burst_space), 32'(tbl[i].bs));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
      chk("tbl_head", bus.out_data, tbl[i].head);
    end

    drive(1, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 32'h100 + 32'(i), 1);
      step();
      chk("stream_level", 32'(level), 1);
      chk("stream_order", bus.out_data, 32'h100 + 32'(i));
    end
    drive(0, 0, 0, 1);
    step();
    chk("stream_drain_level", 32'(level), 0);

    drive(0, 1, 32'hA, 1);
    chk("fwft_write_cycle_out_valid", 32'(bus.out_valid), 0);
    step();
    chk("fwft_out_valid", 32'(bus.out_valid), 1);
    chk("fwft_out_data", bus.out_data, 32'hA);
    drive(0, 0, 0, 1);
    step();
    chk("fwft_pop_level", 32'(level), 0);
    chk("fwft_pop_almost_empty", 32'(almost_empty), 1);

    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 32'h200 + 32'(i), 0);
      step();
    end
    drive(0, 1, 32'h2FF, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      step();
    end
    chk("preflush_level", 32'(level), 5);
    chk("preflush_overflow", 32'(overflow), 1);
    drive(1, 1, 32'hBEEF, 1);
    step();
    chk("flush_level", 32'(level), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_overflow", 32'(overflow), 0);
    drive(0, 0, 0, 0);
    step();
    chk("flush_dropped_level", 32'(level), 0);

    for (int i = 0; i < 600; i++) begin
      bit f, iv, ordy;
      f = ($urandom_range(0, 59) == 0);
      if (i < 300) begin
        iv   = ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 9) < 4);
      end else begin
        iv   = ($urandom_range(0, 9) < 4);
        ordy = ($urandom_range(0, 9) < 7);
      end
      drive(f, iv, $urandom, ordy);
      step();
    end

    drive(1, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h300 + 32'(i), 0);
      step();
    end
    chk("prerst_level", 32'(level), 3);
    drive(0, 1, 32'h377, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 1);
    chk("async_rst_out_valid", 32'(bus.out_valid), 0);
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_hold_level", 32'(level), 0);
    drive(0, 1, 32'h55, 0);
    step();
    drive(0, 1, 32'h66, 1);
    step();
    drive(0, 0, 0, 1);
    step();
    step();
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
